ree_rst_sequencer: RTL and testbench
====================================

// Module: ree_rst_sequencer
// PURPOSE
//  Downstream of the AHB slave-5 REE reset control registers.
//  Turns the software-level reset request (ctrl_rst_b) and boot address into a sequenced REE reset:
//  - guaranteed minimum reset width;
//  - bus-before-core staged release;
//  - quiesce handshake with the REE core before re-asserting reset;
//  - watchdog override.
//  Drives the REE core/bus reset pins and a stable boot vector.
// PARAMETERS
//  HOLD_CYCLES      16   min cycles both resets stay asserted after any entry to HOLD (>=2)
//  STAGE_CYCLES     8    cycles between bus reset release and core reset release (>=1)
//  QUIESCE_TIMEOUT  256  max cycles waiting for ree_idle_ack before forcing reset (>=2)
//  CNT_W            9    shared counter width; must hold max of the three above
// PORTS
//  hclk             in   1   clock
//  hrst_b           in   1   reset, asynchronous, active-low
//  ctrl_rst_b       in   1   level from control regs: 1 = run REE, 0 = hold in reset (hclk domain)
//  ctrl_rst_addr    in   32  boot address from control regs (hclk domain)
//  wdt_rst_req      in   1   single-cycle watchdog reset pulse (hclk domain)
//  ree_idle_ack     in   1   REE core bus-idle acknowledge (async; synchronised internally)
//  ree_idle_req     out  1   request REE core to drain outstanding bus traffic
//  ree_bus_rst_b    out  1   REE bus/interconnect reset, active-low
//  ree_core_rst_b   out  1   REE core reset, active-low
//  ree_rst_vector   out  32  boot vector; stable whenever ree_bus_rst_b=1
//  ree_running      out  1   1 while in RUN
//  rst_cause        out  2   cause of last reset: 0 POR, 1 SW, 2 WDT, 3 QUIESCE timeout
//  ree_rst_cnt      out  8   completed resets since POR, saturating at 255
// BEHAVIOUR
//  Reset (hrst_b=0) values:
//  - state=HOLD, cnt=0; all outputs 0 (ree_bus_rst_b=0, ree_core_rst_b=0, ree_rst_vector=0,
//    ree_idle_req=0, ree_running=0, rst_cause=0, ree_rst_cnt=0).
//  Outputs: all registered; each decoded from next-state, so it changes on the edge the state is entered.
//  States:
//  - HOLD: both resets asserted; cnt counts 0..HOLD_CYCLES-1, then WAIT_REQ. ctrl_rst_b and wdt ignored.
//  - WAIT_REQ: both resets asserted.
//    - ctrl_rst_b=1: latch ree_rst_vector<=ctrl_rst_addr, cnt=0, -> BUS_REL.
//    - wdt_rst_req ignored (REE already in reset).
//  - BUS_REL: ree_bus_rst_b=1, core still in reset; cnt counts 0..STAGE_CYCLES-1, then -> RUN.
//    - ctrl_rst_b=0 or wdt_rst_req: -> HOLD directly, no quiesce (core never ran);
//      cause=SW or WDT, ree_rst_cnt++.
//  - RUN: ree_core_rst_b=1, ree_running=1.
//    - wdt_rst_req: -> HOLD, cause=WDT, cnt++.
//    - else ctrl_rst_b=0: -> QUIESCE, cnt=0.
//    - Both on the same cycle: WDT wins.
//  - QUIESCE: core still out of reset, ree_idle_req=1, ree_running=0.
//    - Synchronised ack=1: -> HOLD, cause=SW.
//    - Else cnt reaches QUIESCE_TIMEOUT-1: -> HOLD, cause=QTO.
//    - wdt_rst_req at any point: -> HOLD, cause=WDT (priority over ack/timeout).
//    - ctrl_rst_b returning to 1 does NOT abort; the reset completes.
//    - ree_idle_req drops on the HOLD entry edge; ree_rst_cnt++ on that edge.
//  Vector rule: ree_rst_vector changes only on the WAIT_REQ->BUS_REL edge, never while the REE runs.
//  Latency:
//  - ctrl_rst_b 0->1 seen in WAIT_REQ -> ree_bus_rst_b=1 next edge;
//    ree_core_rst_b=1 STAGE_CYCLES edges later.
//  - Minimum reset-assert width = HOLD_CYCLES+1 cycles (HOLD + at least one WAIT_REQ cycle).
//  - ree_idle_ack latency = 2 sync flops + 1.
//  Counter: one shared CNT_W-bit counter, cleared on every state change.
//  rst_cause holds its value until the next reset entry.
//  hrst_b mid-operation: immediate async return to reset values, regardless of state.
// STRUCTURE
//  Shared include ree_rst_defines.vh:
//  - state encodings (HOLD, WAIT_REQ, BUS_REL, RUN, QUIESCE);
//  - rst_cause codes (POR, SW, WDT, QTO).
//  The AHB slave-5 register map offsets (0x3000_0000 ctrl, 0x3000_0004 addr) move there too.
//  Sub-module: ree_rst_sync, a 2-flop synchroniser with async active-low reset to 0;
//  instantiated for ree_idle_ack.
//  Top: FSM, shared counter, vector/cause/count registers.
// TESTING
//  1 POR, ctrl_rst_b=1, addr=0x8000_0000 -> bus_rst_b rises at cycle 17 (HOLD 16 + WAIT_REQ);
//    core_rst_b 8 cycles later; vector=0x8000_0000, cause=0, ree_rst_cnt=0.
//  2 RUN; ctrl_rst_b->0; ack rises 5 cycles after idle_req -> HOLD after ack+3 cycles;
//    both resets low, cause=1, ree_rst_cnt=1.
//  3 RUN; ctrl_rst_b->0; ack held 0 -> reset forced after exactly 256 QUIESCE cycles, cause=3.
//  4 wdt_rst_req and ctrl_rst_b=0 on the same RUN cycle -> immediate HOLD, no idle_req, cause=2;
//    wdt pulse during HOLD/WAIT_REQ has no effect.
//  5 ctrl_rst_addr changed to 0x1234_0000 during RUN and BUS_REL -> vector unchanged;
//    the next release picks up the new value.
//  6 ctrl_rst_b drops in BUS_REL cycle 3 -> core_rst_b never rises, bus_rst_b low next edge,
//    cause=1; hrst_b pulsed in QUIESCE -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ree_rst_sequencer_pkg.sv
// Shared REE reset sequencer definitions: state encodings, reset-cause codes
// and the AHB slave-5 control register offsets that feed this block.
package ree_rst_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_HOLD     = 3'd0,
    ST_WAIT_REQ = 3'd1,
    ST_BUS_REL  = 3'd2,
    ST_RUN      = 3'd3,
    ST_QUIESCE  = 3'd4
  } ree_state_e;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'd0,
    CAUSE_SW  = 2'd1,
    CAUSE_WDT = 2'd2,
    CAUSE_QTO = 2'd3
  } ree_cause_e;

  // register map of the upstream AHB slave-5 control block
  localparam logic [31:0] REE_REG_CTRL_ADDR = 32'h3000_0000;
  localparam logic [31:0] REE_REG_BOOT_ADDR = 32'h3000_0004;

endpackage

// File: rtl/ree_rst_sequencer_if.sv
// Control-side inputs and REE-side reset/status outputs of the sequencer.
interface ree_rst_sequencer_if;
  logic        ctrl_rst_b;
  logic [31:0] ctrl_rst_addr;
  logic        wdt_rst_req;
  logic        ree_idle_ack;
  logic        ree_idle_req;
  logic        ree_bus_rst_b;
  logic        ree_core_rst_b;
  logic [31:0] ree_rst_vector;
  logic        ree_running;
  logic [1:0]  rst_cause;
  logic [7:0]  ree_rst_cnt;

  modport slave (
    input  ctrl_rst_b, ctrl_rst_addr, wdt_rst_req, ree_idle_ack,
    output ree_idle_req, ree_bus_rst_b, ree_core_rst_b, ree_rst_vector,
           ree_running, rst_cause, ree_rst_cnt
  );

  modport master (
    output ctrl_rst_b, ctrl_rst_addr, wdt_rst_req, ree_idle_ack,
    input  ree_idle_req, ree_bus_rst_b, ree_core_rst_b, ree_rst_vector,
           ree_running, rst_cause, ree_rst_cnt
  );
endinterface

// File: rtl/ree_rst_sync.sv
// Two-flop synchroniser, async active-low reset to 0.
module ree_rst_sync (
  input  logic hclk,
  input  logic hrst_b,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/ree_rst_sequencer.sv
// REE reset sequencer: minimum-width hold, bus-before-core release, quiesce
// handshake before re-assertion, watchdog override.
//   state    | meaning
//   HOLD     | both resets asserted for HOLD_CYCLES, requests ignored
//   WAIT_REQ | both resets asserted, waiting for ctrl_rst_b=1
//   BUS_REL  | bus out of reset, core held for STAGE_CYCLES
//   RUN      | REE running
//   QUIESCE  | idle requested, waiting for ack / timeout before HOLD
module ree_rst_sequencer
  import ree_rst_sequencer_pkg::*;
#(
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGE_CYCLES    = 8,
  parameter int QUIESCE_TIMEOUT = 256,
  parameter int CNT_W           = 9
) (
  input  logic                 hclk,
  input  logic                 hrst_b,
  ree_rst_sequencer_if.slave   rif
);
  ree_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  ree_cause_e       cause, cause_nxt;
  logic [31:0]      vector, vector_nxt;
  logic [7:0]       rst_cnt;
  logic             rst_inc;
  logic             ack_sync;

  ree_rst_sync u_ack_sync (
    .hclk   (hclk),
    .hrst_b (hrst_b),
    .d      (rif.ree_idle_ack),
    .q      (ack_sync)
  );

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    cause_nxt  = cause;
    vector_nxt = vector;
    rst_inc    = 1'b0;
    case (state)
      ST_HOLD: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_W'(HOLD_CYCLES - 1)) state_nxt = ST_WAIT_REQ;
      end
      ST_WAIT_REQ: begin
        if (rif.ctrl_rst_b) begin
          state_nxt  = ST_BUS_REL;
          vector_nxt = rif.ctrl_rst_addr;
        end
      end
      ST_BUS_REL: begin
        cnt_nxt = cnt + 1'b1;
        // core never ran, so no quiesce is needed to abort here
        if (rif.wdt_rst_req) begin
          state_nxt = ST_HOLD;
          cause_nxt = CAUSE_WDT;
          rst_inc   = 1'b1;
        end else if (!rif.ctrl_rst_b) begin
          state_nxt = ST_HOLD;
          cause_nxt = CAUSE_SW;
          rst_inc   = 1'b1;
        end else if (cnt == CNT_W'(STAGE_CYCLES - 1)) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (rif.wdt_rst_req) begin
          state_nxt = ST_HOLD;
          cause_nxt = CAUSE_WDT;
          rst_inc   = 1'b1;
        end else if (!rif.ctrl_rst_b) begin
          state_nxt = ST_QUIESCE;
        end
      end
      ST_QUIESCE: begin
        cnt_nxt   = cnt + 1'b1;
        state_nxt = ST_HOLD;
        rst_inc   = 1'b1;
        if (rif.wdt_rst_req)                          cause_nxt = CAUSE_WDT;
        else if (ack_sync)                            cause_nxt = CAUSE_SW;
        else if (cnt == CNT_W'(QUIESCE_TIMEOUT - 1))  cause_nxt = CAUSE_QTO;
        else begin
          state_nxt = ST_QUIESCE;
          rst_inc   = 1'b0;
        end
      end
      default: state_nxt = ST_HOLD;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b) begin
      state              <= ST_HOLD;
      cnt                <= '0;
      cause              <= CAUSE_POR;
      vector             <= '0;
      rst_cnt            <= '0;
      rif.ree_bus_rst_b  <= 1'b0;
      rif.ree_core_rst_b <= 1'b0;
      rif.ree_idle_req   <= 1'b0;
      rif.ree_running    <= 1'b0;
    end else begin
      state              <= state_nxt;
      cnt                <= cnt_nxt;
      cause              <= cause_nxt;
      vector             <= vector_nxt;
      if (rst_inc && rst_cnt != 8'hFF) rst_cnt <= rst_cnt + 1'b1;
      rif.ree_bus_rst_b  <= state_nxt inside {ST_BUS_REL, ST_RUN, ST_QUIESCE};
      rif.ree_core_rst_b <= state_nxt inside {ST_RUN, ST_QUIESCE};
      rif.ree_idle_req   <= state_nxt == ST_QUIESCE;
      rif.ree_running    <= state_nxt == ST_RUN;
    end
  end

  assign rif.ree_rst_vector = vector;
  assign rif.rst_cause      = cause;
  assign rif.ree_rst_cnt    = rst_cnt;
endmodule

// File: tb/tb_ree_rst_sequencer.sv
// Directed bench for ree_rst_sequencer with a scoreboard of expected values.
module tb_ree_rst_sequencer;
  logic hclk = 1'b0;
  logic hrst_b;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n;

  string       exp_tag_q[$];
  logic [31:0] exp_val_q[$];

  localparam int S_BUS  = 0;
  localparam int S_CORE = 1;
  localparam int S_REQ  = 2;

  ree_rst_sequencer_if rif ();

  ree_rst_sequencer dut (
    .hclk   (hclk),
    .hrst_b (hrst_b),
    .rif    (rif.slave)
  );

  always #5 hclk = ~hclk;

  task automatic push(input string tag, input logic [31:0] val);
    exp_tag_q.push_back(tag);
    exp_val_q.push_back(val);
  endtask

  task automatic chk(input logic [31:0] obs);
    string       tag;
    logic [31:0] e;
    n_cmp++;
    if (exp_val_q.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty: observed %0h required an expected entry", obs);
    end else begin
      tag = exp_tag_q.pop_front();
      e   = exp_val_q.pop_front();
      assert (obs === e) else begin
        n_bad++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  // counts falling edges until the selected output reaches val
  task automatic wait_sig(input int sel, input logic val, input int max_cyc, output int cnt);
    logic s;
    cnt = 0;
    do begin
      @(negedge hclk);
      cnt++;
      case (sel)
        S_BUS:   s = rif.ree_bus_rst_b;
        S_CORE:  s = rif.ree_core_rst_b;
        default: s = rif.ree_idle_req;
      endcase
    end while (s !== val && cnt < max_cyc);
    if (s !== val) begin
      n_cmp++;
      n_bad++;
      $error("FAIL timeout_sel%0d: observed %b expected %b", sel, s, val);
    end
  endtask

  initial begin
    hrst_b            = 1'b0;
    rif.ctrl_rst_b    = 1'b1;
    rif.ctrl_rst_addr = 32'h8000_0000;
    rif.wdt_rst_req   = 1'b0;
    rif.ree_idle_ack  = 1'b0;
    repeat (3) @(negedge hclk);

    // 1: power-on values, then release timing
    push("por_bus", 0);  chk(32'(rif.ree_bus_rst_b));
    push("por_core", 0); chk(32'(rif.ree_core_rst_b));
    push("por_vec", 0);  chk(rif.ree_rst_vector);
    push("por_req", 0);  chk(32'(rif.ree_idle_req));
    push("por_cnt", 0);  chk(32'(rif.ree_rst_cnt));
    hrst_b = 1'b1;
    push("t1_bus_lat", 17);
    wait_sig(S_BUS, 1'b1, 40, n); chk(32'(n));
    push("t1_core_lat", 8);
    wait_sig(S_CORE, 1'b1, 20, n); chk(32'(n));
    push("t1_vec", 32'h8000_0000); chk(rif.ree_rst_vector);
    push("t1_cause", 0);           chk(32'(rif.rst_cause));
    push("t1_rcnt", 0);            chk(32'(rif.ree_rst_cnt));
    push("t1_running", 1);         chk(32'(rif.ree_running));

    // 2: software reset with idle acknowledge
    rif.ctrl_rst_b = 1'b0;
    push("t2_req_lat", 1);
    wait_sig(S_REQ, 1'b1, 5, n); chk(32'(n));
    push("t2_running", 0); chk(32'(rif.ree_running));
    repeat (5) @(negedge hclk);
    rif.ree_idle_ack = 1'b1;
    push("t2_ack_lat", 3);
    wait_sig(S_BUS, 1'b0, 10, n); chk(32'(n));
    rif.ree_idle_ack = 1'b0;
    push("t2_core", 0);  chk(32'(rif.ree_core_rst_b));
    push("t2_req", 0);   chk(32'(rif.ree_idle_req));
    push("t2_cause", 1); chk(32'(rif.rst_cause));
    push("t2_rcnt", 1);  chk(32'(rif.ree_rst_cnt));
    rif.ctrl_rst_b = 1'b1;
    push("t2_min_width", 17);
    wait_sig(S_BUS, 1'b1, 40, n); chk(32'(n));
    push("t2_core_lat", 8);
    wait_sig(S_CORE, 1'b1, 20, n); chk(32'(n));

    // 3: quiesce timeout
    rif.ctrl_rst_b = 1'b0;
    push("t3_req_lat", 1);
    wait_sig(S_REQ, 1'b1, 5, n); chk(32'(n));
    push("t3_qto_len", 256);
    wait_sig(S_BUS, 1'b0, 400, n); chk(32'(n));
    push("t3_cause", 3); chk(32'(rif.rst_cause));
    push("t3_rcnt", 2);  chk(32'(rif.ree_rst_cnt));
    push("t3_req", 0);   chk(32'(rif.ree_idle_req));

    // 4: watchdog wins over ctrl_rst_b, ignored in HOLD/WAIT_REQ
    rif.ctrl_rst_b = 1'b1;
    push("t4_bus_lat", 17);
    wait_sig(S_BUS, 1'b1, 40, n); chk(32'(n));
    push("t4_core_lat", 8);
    wait_sig(S_CORE, 1'b1, 20, n); chk(32'(n));
    rif.ctrl_rst_b  = 1'b0;
    rif.wdt_rst_req = 1'b1;
    push("t4_bus", 0);   push("t4_core", 0); push("t4_req", 0);
    push("t4_cause", 2); push("t4_rcnt", 3);
    @(negedge hclk);
    rif.wdt_rst_req = 1'b0;
    chk(32'(rif.ree_bus_rst_b)); chk(32'(rif.ree_core_rst_b));
    chk(32'(rif.ree_idle_req));  chk(32'(rif.rst_cause));
    chk(32'(rif.ree_rst_cnt));
    rif.wdt_rst_req = 1'b1;
    @(negedge hclk);
    rif.wdt_rst_req = 1'b0;
    push("t4_hold_wdt_rcnt", 3); chk(32'(rif.ree_rst_cnt));
    repeat (20) @(negedge hclk);
    rif.wdt_rst_req = 1'b1;
    @(negedge hclk);
    rif.wdt_rst_req = 1'b0;
    push("t4_wait_wdt_rcnt", 3); chk(32'(rif.ree_rst_cnt));
    push("t4_wait_wdt_bus", 0);  chk(32'(rif.ree_bus_rst_b));

    // 5: boot address changes while running are not picked up until next release
    rif.ctrl_rst_b = 1'b1;
    push("t5_bus_lat", 1);
    wait_sig(S_BUS, 1'b1, 5, n); chk(32'(n));
    rif.ctrl_rst_addr = 32'h1234_0000;
    @(negedge hclk);
    push("t5_vec_busrel", 32'h8000_0000); chk(rif.ree_rst_vector);
    push("t5_core_lat", 7);
    wait_sig(S_CORE, 1'b1, 20, n); chk(32'(n));
    @(negedge hclk);
    push("t5_vec_run", 32'h8000_0000); chk(rif.ree_rst_vector);
    rif.ctrl_rst_b = 1'b0;
    push("t5_req_lat", 1);
    wait_sig(S_REQ, 1'b1, 5, n); chk(32'(n));
    rif.ree_idle_ack = 1'b1;
    push("t5_ack_lat", 3);
    wait_sig(S_BUS, 1'b0, 10, n); chk(32'(n));
    rif.ree_idle_ack = 1'b0;
    rif.ctrl_rst_b   = 1'b1;
    push("t5_bus_lat2", 17);
    wait_sig(S_BUS, 1'b1, 40, n); chk(32'(n));
    push("t5_vec_new", 32'h1234_0000); chk(rif.ree_rst_vector);
    push("t5_rcnt", 4);                chk(32'(rif.ree_rst_cnt));

    // 6: abort during BUS_REL, then async reset during QUIESCE
    @(negedge hclk);
    push("t6_core_busrel", 0); chk(32'(rif.ree_core_rst_b));
    @(negedge hclk);
    rif.ctrl_rst_b = 1'b0;
    push("t6_bus", 0); push("t6_core", 0); push("t6_cause", 1); push("t6_rcnt", 5);
    @(negedge hclk);
    chk(32'(rif.ree_bus_rst_b)); chk(32'(rif.ree_core_rst_b));
    chk(32'(rif.rst_cause));     chk(32'(rif.ree_rst_cnt));
    rif.ctrl_rst_b = 1'b1;
    push("t6_bus_lat", 17);
    wait_sig(S_BUS, 1'b1, 40, n); chk(32'(n));
    push("t6_core_lat", 8);
    wait_sig(S_CORE, 1'b1, 20, n); chk(32'(n));
    rif.ctrl_rst_b = 1'b0;
    push("t6_req_lat", 1);
    wait_sig(S_REQ, 1'b1, 5, n); chk(32'(n));
    repeat (2) @(negedge hclk);
    #2;
    hrst_b = 1'b0;
    #1;
    push("arst_bus", 0);  chk(32'(rif.ree_bus_rst_b));
    push("arst_core", 0); chk(32'(rif.ree_core_rst_b));
    push("arst_req", 0);  chk(32'(rif.ree_idle_req));
    push("arst_run", 0);  chk(32'(rif.ree_running));
    push("arst_vec", 0);  chk(rif.ree_rst_vector);
    push("arst_cause", 0); chk(32'(rif.rst_cause));
    push("arst_rcnt", 0); chk(32'(rif.ree_rst_cnt));
    @(negedge hclk);
    hrst_b = 1'b1;
    repeat (2) @(negedge hclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
